// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the instruction-fetch controller, instruction memory and decode.
// master = fetch controller side, slave = memory/decode/testbench side.
interface imem_fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] stall_cnt;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output stall_cnt
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  stall_cnt
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: sequential PC generation feeding a 2-entry {pc, instr}
// queue toward decode, with redirect flush and a saturating back-pressure stall counter.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        out_valid;
    logic        push;
    logic        pop;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        stall_cnt_d  = stall_cnt_q;

        // out_valid is a function of state and redirect only, never of out_ready
        out_valid = (state_q != EMPTY) && !bus.redirect_valid;
        pop       = out_valid && bus.out_ready;
        push      = !bus.redirect_valid && ((state_q != FULL) || pop);

        if (bus.redirect_valid) begin
            state_d    = EMPTY;
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_pc_d    = fetch_pc_q;
                        head_instr_d = bus.imem_data;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_pc_d    = fetch_pc_q;
                        head_instr_d = bus.imem_data;
                    end else if (push) begin
                        tail_pc_d    = fetch_pc_q;
                        tail_instr_d = bus.imem_data;
                        state_d      = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Older tail slides to head; a simultaneous fetch refills the tail
                    if (pop) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        if (push) begin
                            tail_pc_d    = fetch_pc_q;
                            tail_instr_d = bus.imem_data;
                        end else begin
                            state_d = ONE;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase

            if ((state_q == FULL) && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            fetch_pc_q   <= RESET_PC;
            head_pc_q    <= 32'd0;
            head_instr_q <= 32'd0;
            tail_pc_q    <= 32'd0;
            tail_instr_q <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = (state_q == EMPTY) ? 32'd0 : head_pc_q;
    assign bus.out_instr = (state_q == EMPTY) ? 32'd0 : head_instr_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed and random checks of imem_fetch_ctrl; expected pops are queued as stimulus
// is applied and compared when the DUT presents them to decode.
module tb_imem_fetch_ctrl;
    logic clk;
    logic rst_n;

    imem_fetch_ctrl_if bus ();
    imem_fetch_ctrl_if bus2 ();

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.master)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pops    = 0;
    bit          stress  = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_next_pc;

    // Memory image: word i holds i+1
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    always_comb bus.imem_data  = mem_f(bus.imem_addr);
    always_comb bus2.imem_data = mem_f(bus2.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // Called at the negedge: a pop happens at the coming edge if valid && ready
    task automatic sample_pop();
        logic [31:0] e;
        if (bus.out_valid && bus.out_ready) begin
            if (stress) begin
                e           = exp_next_pc;
                exp_next_pc = e + 32'd4;
            end else if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL pop_unexpected observed pc=%h expected no pop", bus.out_pc);
                return;
            end else begin
                e = exp_q.pop_front();
            end
            chk("pop_pc", bus.out_pc, e);
            chk("pop_instr", bus.out_instr, mem_f(e));
            $display("[TB] pop pc=%h instr=%h", bus.out_pc, bus.out_instr);
            pops++;
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.out_ready       = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'd0;
        bus2.out_ready      = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'd0;
        exp_next_pc         = 32'd0;

        // Reset state
        repeat (2) to_pos();
        to_neg();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc", bus.out_pc, 32'd0);
        chk("rst_instr", bus.out_instr, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_stall", bus.stall_cnt, 32'd0);
        chk("rst_addr_wrap", bus2.imem_addr, 32'hFFFF_FFF8);
        to_pos();

        // Streaming from reset with decode always ready; wrap instance runs alongside
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        to_neg();
        chk("lat_cycle0_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_cycle0_addr", bus.imem_addr, 32'd0);
        sample_pop();
        to_pos();
        for (int k = 0; k < 4; k++) begin
            to_neg();
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            sample_pop();
            chk("wrap_pc", bus2.out_pc, 32'hFFFF_FFF8 + 32'(4 * k));
            chk("wrap_instr", bus2.out_instr, mem_f(32'hFFFF_FFF8 + 32'(4 * k)));
            to_pos();
        end
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure after reset: fills to FULL and counts stalls
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        to_pos();
        rst_n = 1'b1;
        exp_q.delete();
        repeat (5) to_pos();
        bus.out_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        to_neg();
        chk("full_head_pc", bus.out_pc, 32'h0);
        chk("full_addr", bus.imem_addr, 32'h8);
        chk("full_stall", bus.stall_cnt, 32'd3);
        sample_pop();
        to_pos();
        repeat (2) begin
            to_neg();
            sample_pop();
            to_pos();
        end
        chk("full_drained", 32'(exp_q.size()), 32'd0);
        chk("full_stall_hold", bus.stall_cnt, 32'd3);

        // Redirect pulse while FULL
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0023;
        exp_q.delete();
        to_neg();
        chk("rd_valid_low", 32'(bus.out_valid), 32'd0);
        to_pos();
        bus.redirect_valid = 1'b0;
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h24);
        to_neg();
        chk("rd_addr", bus.imem_addr, 32'h20);
        chk("rd_empty_valid", 32'(bus.out_valid), 32'd0);
        to_pos();
        repeat (2) begin
            to_neg();
            sample_pop();
            to_pos();
        end
        chk("rd_drained", 32'(exp_q.size()), 32'd0);

        // Held redirect with target changing on the final cycle
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.redirect_pc = 32'h0000_0200;
            to_neg();
            chk("hold_valid_low", 32'(bus.out_valid), 32'd0);
            if (i > 0) chk("hold_addr", bus.imem_addr, 32'h100);
            to_pos();
        end
        bus.redirect_valid = 1'b0;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        to_neg();
        chk("hold_release_addr", bus.imem_addr, 32'h200);
        to_pos();
        repeat (2) begin
            to_neg();
            sample_pop();
            to_pos();
        end
        chk("hold_drained", 32'(exp_q.size()), 32'd0);

        // Redirect to the top word: fetch PC wraps to zero
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        exp_q.delete();
        to_pos();
        bus.redirect_valid = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        repeat (4) begin
            to_neg();
            sample_pop();
            to_pos();
        end
        chk("pcwrap_drained", 32'(exp_q.size()), 32'd0);

        // Reset asserted together with redirect while FULL
        bus.out_ready = 1'b0;
        repeat (3) to_pos();
        to_neg();
        chk("prerst_valid", 32'(bus.out_valid), 32'd1);
        chk("prerst_stall", bus.stall_cnt, 32'd5);
        to_pos();
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0400;
        exp_q.delete();
        to_pos();
        rst_n              = 1'b1;
        bus.redirect_valid = 1'b0;
        to_neg();
        chk("rstov_valid", 32'(bus.out_valid), 32'd0);
        chk("rstov_addr", bus.imem_addr, 32'h0);
        chk("rstov_stall", bus.stall_cnt, 32'd0);
        chk("rstov_pc", bus.out_pc, 32'd0);
        chk("rstov_instr", bus.out_instr, 32'd0);
        to_pos();

        // Random ready/redirect stress against a running expected PC
        stress      = 1'b1;
        exp_next_pc = 32'h0;
        pops        = 0;
        for (int c = 0; c < 600; c++) begin
            logic        redir;
            logic [31:0] rpc;
            redir              = ($urandom_range(0, 15) == 0);
            rpc                = $urandom;
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = redir;
            bus.redirect_pc    = rpc;
            if (redir) exp_next_pc = rpc & 32'hFFFF_FFFC;
            to_neg();
            if (redir) chk("st_rd_valid", 32'(bus.out_valid), 32'd0);
            sample_pop();
            to_pos();
        end
        bus.redirect_valid = 1'b0;
        chk("st_liveness", 32'(pops > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
